mdu_sequencer: RTL and testbench

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers and models the fixed multi-cycle latency of MULT/MULTU/DIV/DIVU. It also exports the start/busy indications that the stall controller uses to hold MD-class instructions in D. MTHI/MTLO writes and all HI/LO reads go through this block; operands arrive already forwarded (post-FMUX V1_E/V2_E).

---
 rtl/mdu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed MD latency.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by `define MDU_MADD_EN.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  MDU_Op_E,
  input  logic        MDU_Valid_E,
  input  logic [31:0] V1_E,
  input  logic [31:0] V2_E,
  output logic        MDU_Start,
  output logic        MDU_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDU_Err
);

  // state | meaning
  // IDLE  | no operation in flight; starts, MTHI and MTLO accepted
  // BUSY  | result pending in pend_hi/pend_lo, cnt counts down to commit
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic        err, err_nxt;

  logic        op_mul, op_mulu, op_div, op_divu, op_mthi, op_mtlo, op_macc;
  logic        op_start, op_any;
  logic [63:0] prod_s, prod_u, res;
  logic [7:0]  n_cyc;

  assign op_mul  = (MDU_Op_E == 4'b0001);
  assign op_mulu = (MDU_Op_E == 4'b0010);
  assign op_div  = (MDU_Op_E == 4'b0011);
  assign op_divu = (MDU_Op_E == 4'b0100);
  assign op_mthi = (MDU_Op_E == 4'b0101);
  assign op_mtlo = (MDU_Op_E == 4'b0110);

  assign prod_s = $signed({{32{V1_E[31]}}, V1_E}) * $signed({{32{V2_E[31]}}, V2_E});
  assign prod_u = {32'd0, V1_E} * {32'd0, V2_E};

`ifdef MDU_MADD_EN
  logic [63:0] macc_res;
  assign op_macc = (MDU_Op_E >= 4'b0111) && (MDU_Op_E <= 4'b1010);

  // Accumulate base is the architectural {HI,LO} at the moment of start.
  always_comb begin
    macc_res = {hi, lo};
    case (MDU_Op_E)
      4'b0111: macc_res = {hi, lo} + prod_s;
      4'b1000: macc_res = {hi, lo} + prod_u;
      4'b1001: macc_res = {hi, lo} - prod_s;
      4'b1010: macc_res = {hi, lo} - prod_u;
      default: macc_res = {hi, lo};
    endcase
  end
`else
  logic [63:0] macc_res;
  assign op_macc  = 1'b0;
  assign macc_res = 64'd0;
`endif

  // Sign-magnitude divide shared by DIV and DIVU; truncation toward zero falls out naturally.
  logic        a_neg, b_neg;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quo, rem;

  assign a_neg    = op_div & V1_E[31];
  assign b_neg    = op_div & V2_E[31];
  assign num      = a_neg ? (~V1_E + 32'd1) : V1_E;
  assign den      = b_neg ? (~V2_E + 32'd1) : V2_E;
  assign den_safe = (den == 32'd0) ? 32'd1 : den;
  assign q_mag    = num / den_safe;
  assign r_mag    = num % den_safe;
  assign quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign op_start  = op_mul | op_mulu | op_div | op_divu | op_macc;
  assign op_any    = op_start | op_mthi | op_mtlo;
  assign MDU_Start = MDU_Valid_E & op_start & (state == IDLE);
  assign n_cyc     = (op_div | op_divu) ? DIV_N : MULT_N;

  always_comb begin
    res = {hi, lo};
    if (op_mul)
      res = prod_s;
    else if (op_mulu)
      res = prod_u;
    else if (op_div | op_divu) begin
      if (V2_E != 32'd0)
        res = {rem, quo};
    end else if (op_macc)
      res = macc_res;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    err_nxt     = err;
    case (state)
      IDLE: begin
        if (MDU_Start) begin
          // cnt holds edges remaining minus one, so the commit lands on edge t+N.
          if (n_cyc == 8'd1) begin
            hi_nxt = res[63:32];
            lo_nxt = res[31:0];
          end else begin
            pend_hi_nxt = res[63:32];
            pend_lo_nxt = res[31:0];
            cnt_nxt     = n_cyc - 8'd1;
            state_nxt   = BUSY;
          end
        end else if (MDU_Valid_E & op_mthi)
          hi_nxt = V1_E;
        else if (MDU_Valid_E & op_mtlo)
          lo_nxt = V1_E;
      end
      BUSY: begin
        if (MDU_Valid_E & op_any)
          err_nxt = 1'b1;
        if (cnt == 8'd1) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else
          cnt_nxt = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      err     <= err_nxt;
    end
  end

  assign MDU_Busy = (state == BUSY);
  assign HI       = hi;
  assign LO       = lo;
  assign MDU_Err  = err;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  op;
  logic        valid;
  logic [31:0] v1, v2;
  logic        start, busy, err;
  logic [31:0] hi, lo;
  int          tests = 0;
  int          fails = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .MDU_Op_E(op), .MDU_Valid_E(valid),
    .V1_E(v1), .V2_E(v2), .MDU_Start(start), .MDU_Busy(busy),
    .HI(hi), .LO(lo), .MDU_Err(err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; valid = 1'b1; v1 = a; v2 = b;
    #1;
  endtask

  task automatic idle_in();
    op = 4'd0; valid = 1'b0; v1 = 32'd0; v2 = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    reset_n = 1'b0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got %h:%h exp 0:0", hi, lo); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got %b exp 0", start); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    drive(4'b0001, 32'hFFFFFFFE, 32'd3);
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL mult_start got %b exp 1", start); end
    step(); idle_in();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mult_busy_t1 got %b exp 1", busy); end
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k < 5) begin
        tests++; if (busy !== 1'b1 || hi !== 32'd0) begin fails++; $display("FAIL mult_mid k=%0d busy=%b hi=%h exp 1/0", k, busy, hi); end
      end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_done_busy got %b exp 0", busy); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_result got %h:%h exp ffffffff:fffffffa", hi, lo); end
  endtask

  task automatic test_div_back_to_back();
    drive(4'b0011, 32'hFFFFFFF9, 32'd2);
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL div_start got %b exp 1", start); end
    step(); idle_in();
    for (int k = 2; k <= 10; k++) begin
      step();
      if (k == 9) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL div_busy_t9 got %b exp 1", busy); end
      end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div_done_busy got %b exp 0", busy); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_result got %h:%h exp ffffffff:fffffffd", hi, lo); end
    drive(4'b0100, 32'd100, 32'd7);
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL divu_b2b_start got %b exp 1", start); end
    step(); idle_in();
    for (int k = 2; k <= 10; k++) step();
    tests++; if (hi !== 32'd2 || lo !== 32'd14) begin fails++; $display("FAIL divu_result got %h:%h exp 2:e", hi, lo); end
  endtask

  task automatic test_div_special();
    drive(4'b0101, 32'h1234, 32'd0);
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL mthi_start got %b exp 0", start); end
    step(); idle_in();
    tests++; if (hi !== 32'h1234 || busy !== 1'b0) begin fails++; $display("FAIL mthi got hi=%h busy=%b exp 1234/0", hi, busy); end
    drive(4'b0110, 32'h5678, 32'd0);
    step(); idle_in();
    tests++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo got %h exp 5678", lo); end
    drive(4'b0100, 32'd5, 32'd0);
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL divz_start got %b exp 1", start); end
    step(); idle_in();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL divz_busy got %b exp 1", busy); end
    for (int k = 2; k <= 10; k++) step();
    tests++; if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL divz_result got %b %h:%h exp 0 1234:5678", busy, hi, lo); end
    drive(4'b0011, 32'h80000000, 32'hFFFFFFFF);
    step(); idle_in();
    for (int k = 2; k <= 10; k++) step();
    tests++; if (hi !== 32'd0 || lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf got %h:%h exp 0:80000000", hi, lo); end
  endtask

  task automatic test_op_while_busy();
    drive(4'b0010, 32'h00010000, 32'h00030003);
    step(); idle_in();
    step();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL busy_err_pre got %b exp 0", err); end
    drive(4'b0110, 32'hAAAA, 32'd0);
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL busy_start got %b exp 0", start); end
    step(); idle_in();
    tests++; if (err !== 1'b1 || lo !== 32'h80000000) begin fails++; $display("FAIL busy_ignore got err=%b lo=%h exp 1/80000000", err, lo); end
    step(); step();
    tests++; if (busy !== 1'b0 || hi !== 32'h3 || lo !== 32'h00030000 || err !== 1'b1) begin
      fails++; $display("FAIL busy_final got %b %h:%h err=%b exp 0 3:30000 1", busy, hi, lo, err);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b0011, 32'd100, 32'd5);
    step(); idle_in();
    step(); step(); step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_pre got %b exp 1", busy); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || err !== 1'b0) begin
      fails++; $display("FAIL rstmid_now got %b %h:%h err=%b exp 0 0:0 0", busy, hi, lo, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) step();
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL rstmid_nocommit got %b %h:%h exp 0 0:0", busy, hi, lo); end
  endtask

  task automatic test_madd();
    drive(4'b0101, 32'd0, 32'd0);
    step(); idle_in();
    drive(4'b0110, 32'hFFFFFFFF, 32'd0);
    step(); idle_in();
    drive(4'b1000, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL maddu_start got %b exp 1", start); end
    step(); idle_in();
    for (int k = 2; k <= 5; k++) step();
    tests++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd0) begin fails++; $display("FAIL maddu_result got %b %h:%h exp 0 1:0", busy, hi, lo); end
`else
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL maddu_nostart got %b exp 0", start); end
    step(); idle_in();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL maddu_nobusy got %b exp 0", busy); end
    for (int k = 0; k < 5; k++) step();
    tests++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF || err !== 1'b0) begin fails++; $display("FAIL maddu_noop got %h:%h err=%b exp 0:ffffffff 0", hi, lo, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_back_to_back();
    test_div_special();
    test_op_while_busy();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
